atmospheric_light: RTL and testbench



---
 rtl/haze_pkg.sv | 24 ++
 rtl/atmos_iir_clamp.sv | 61 ++++++
 rtl/atmospheric_light.sv | 155 +++++++++++++++
 tb/tb_atmospheric_light.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal pipeline stages: pixel widths,
// RGB channel slice positions, the atmospheric-light reset value and the
// state type of the atmospheric-light commit sequencer.
package haze_pkg;

    localparam int PIX_W = 8;
    localparam int RGB_W = 24;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

    localparam logic [PIX_W-1:0] A_RESET = 8'hFF;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        UPD1  = 2'd1,
        UPD2  = 2'd2
    } atmos_state_e;

endpackage

// File: rtl/atmos_iir_clamp.sv
// One colour channel of the atmospheric-light commit datapath: the
// inter-frame IIR step (bypassed for the very first frame) followed by the
// floor clamp. The channel keeps its own committed output, which is also
// the "old" value the next smoothing step starts from.
module atmos_iir_clamp
    import haze_pkg::*;
#(
    parameter int SMOOTH_SHIFT = 2,
    parameter int A_FLOOR      = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] cand_i,
    input  logic             first_done_i,
    input  logic             load_s_i,
    input  logic             load_out_i,
    output logic [PIX_W-1:0] out_o
);

    localparam logic signed [9:0] FLOOR10 = 10'(A_FLOOR);

    logic signed [9:0] diff;
    logic signed [9:0] step;
    logic signed [9:0] s_d;
    logic signed [9:0] s_q;
    logic [PIX_W-1:0]  out_d;
    logic [PIX_W-1:0]  out_q;

    // Smoothed value: the arithmetic shift rounds toward -inf, so the result
    // always lies between the old and the candidate value (0..255).
    always_comb begin
        diff = $signed({2'b00, cand_i}) - $signed({2'b00, out_q});
        step = diff >>> SMOOTH_SHIFT;
        s_d  = first_done_i ? ($signed({2'b00, out_q}) + step)
                            : $signed({2'b00, cand_i});
    end

    // Floor clamp applied to the registered smoothed value.
    always_comb begin
        out_d = (s_q < FLOOR10) ? FLOOR10[PIX_W-1:0] : s_q[PIX_W-1:0];
    end

    // Two-stage register pair: smoothed value in the first update cycle,
    // clamped output in the second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            out_q <= A_RESET;
        end else begin
            if (load_s_i) begin
                s_q <= s_d;
            end
            if (load_out_i) begin
                out_q <= out_d;
            end
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/atmospheric_light.sv
// Atmospheric-light estimator: tracks the brightest dark-channel pixel of
// each frame (raster-first on ties), and at every frame boundary commits its
// RGB through the per-channel smoothing/clamp datapath. The committed value
// stays stable for the whole following frame.
module atmospheric_light
    import haze_pkg::*;
#(
    parameter int SMOOTH_SHIFT = 2,
    parameter int A_FLOOR      = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic [PIX_W-1:0] per_dark,
    input  logic [RGB_W-1:0] per_img,
    output logic [PIX_W-1:0] atmos_r,
    output logic [PIX_W-1:0] atmos_g,
    output logic [PIX_W-1:0] atmos_b,
    output logic [PIX_W-1:0] atmos_dark_max,
    output logic             atmos_valid,
    output logic             atmos_update
);

    atmos_state_e     state_q;
    atmos_state_e     state_d;
    logic             vsync_q;
    logic             rise;
    logic             candValid_q;
    logic [PIX_W-1:0] candDark_q;
    logic [RGB_W-1:0] candRgb_q;
    logic [PIX_W-1:0] commitDark_q;
    logic [RGB_W-1:0] commitRgb_q;
    logic             firstDone_q;
    logic [PIX_W-1:0] darkMax_q;
    logic             update_q;
    logic             commitNow;
    logic             unusedHref;

    // Line valid carries no information this stage needs.
    assign unusedHref = per_frame_href;

    assign rise      = per_frame_vsync & ~vsync_q;
    assign commitNow = rise && candValid_q && (state_q == ACCUM);

    // Delayed vsync for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= per_frame_vsync;
        end
    end

    // Per-frame maximum search; a pixel arriving with the rise opens the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candValid_q <= 1'b0;
            candDark_q  <= '0;
            candRgb_q   <= '0;
        end else if (rise) begin
            candValid_q <= per_frame_clken;
            if (per_frame_clken) begin
                candDark_q <= per_dark;
                candRgb_q  <= per_img;
            end
        end else if (per_frame_clken && (!candValid_q || per_dark > candDark_q)) begin
            candValid_q <= 1'b1;
            candDark_q  <= per_dark;
            candRgb_q   <= per_img;
        end
    end

    // Snapshot of the finished frame's winner, used by the update cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commitDark_q <= '0;
            commitRgb_q  <= '0;
        end else if (commitNow) begin
            commitDark_q <= candDark_q;
            commitRgb_q  <= candRgb_q;
        end
    end

    // Update sequencer; a rise during an update is ignored so it can finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (commitNow) state_d = UPD1;
            UPD1:    state_d = UPD2;
            UPD2:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Status outputs written together with the clamped channel values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            firstDone_q <= 1'b0;
            darkMax_q   <= '0;
            update_q    <= 1'b0;
        end else begin
            update_q <= (state_q == UPD2);
            if (state_q == UPD2) begin
                firstDone_q <= 1'b1;
                darkMax_q   <= commitDark_q;
            end
        end
    end

    atmos_iir_clamp #(.SMOOTH_SHIFT(SMOOTH_SHIFT), .A_FLOOR(A_FLOOR)) uChanR (
        .clk          (clk),
        .rst          (rst),
        .cand_i       (commitRgb_q[R_HI:R_LO]),
        .first_done_i (firstDone_q),
        .load_s_i     (state_q == UPD1),
        .load_out_i   (state_q == UPD2),
        .out_o        (atmos_r)
    );

    atmos_iir_clamp #(.SMOOTH_SHIFT(SMOOTH_SHIFT), .A_FLOOR(A_FLOOR)) uChanG (
        .clk          (clk),
        .rst          (rst),
        .cand_i       (commitRgb_q[G_HI:G_LO]),
        .first_done_i (firstDone_q),
        .load_s_i     (state_q == UPD1),
        .load_out_i   (state_q == UPD2),
        .out_o        (atmos_g)
    );

    atmos_iir_clamp #(.SMOOTH_SHIFT(SMOOTH_SHIFT), .A_FLOOR(A_FLOOR)) uChanB (
        .clk          (clk),
        .rst          (rst),
        .cand_i       (commitRgb_q[B_HI:B_LO]),
        .first_done_i (firstDone_q),
        .load_s_i     (state_q == UPD1),
        .load_out_i   (state_q == UPD2),
        .out_o        (atmos_b)
    );

    assign atmos_dark_max = darkMax_q;
    assign atmos_valid    = firstDone_q;
    assign atmos_update   = update_q;

endmodule

// File: tb/tb_atmospheric_light.sv
// Bench for atmospheric_light: two instances (smoothing shift 2 and shift 0,
// both with floor 100) share one pixel stream. A frame-level reference model
// stores each frame's pixels, picks the first maximum at the boundary and
// computes the committed light with floor-division arithmetic.
module tb_atmospheric_light;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic        clken;
    logic [7:0]  dark;
    logic [23:0] img;

    logic [7:0]  outR [2];
    logic [7:0]  outG [2];
    logic [7:0]  outB [2];
    logic [7:0]  outD [2];
    logic        outV [2];
    logic        outU [2];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          mA [2][3];
    int          mDark [2];
    int          mValid [2];
    int          mFirst [2];
    int          pendA [2][3];
    int          pendDark;
    int          pend;
    logic        prevV;
    int          qDark [$];
    logic [23:0] qRgb [$];

    int          pulseAt;
    int          pxDark [16];
    logic [23:0] pxRgb [16];

    always #5 clk = ~clk;

    atmospheric_light #(.SMOOTH_SHIFT(2), .A_FLOOR(100)) dut0 (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_dark(dark), .per_img(img),
        .atmos_r(outR[0]), .atmos_g(outG[0]), .atmos_b(outB[0]),
        .atmos_dark_max(outD[0]), .atmos_valid(outV[0]), .atmos_update(outU[0])
    );

    atmospheric_light #(.SMOOTH_SHIFT(0), .A_FLOOR(100)) dut1 (
        .clk(clk), .rst(rst), .per_frame_vsync(vsync), .per_frame_href(href),
        .per_frame_clken(clken), .per_dark(dark), .per_img(img),
        .atmos_r(outR[1]), .atmos_g(outG[1]), .atmos_b(outB[1]),
        .atmos_dark_max(outD[1]), .atmos_valid(outV[1]), .atmos_update(outU[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input int exp);
        total++;
        if (obs !== 32'(exp)) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clampFloor(input int v);
        return (v < 100) ? 100 : v;
    endfunction

    // Committed value: first frame takes the candidate, later frames move a
    // 1/2^k fraction of the way toward it, rounding toward minus infinity.
    function automatic int smoothCh(input int oldV, input int candV, input int k, input int first);
        int d;
        int p;
        int q;
        if (first == 0) return clampFloor(candV);
        d = candV - oldV;
        p = 1 << k;
        if (d >= 0) q = d / p;
        else        q = -((-d + p - 1) / p);
        return clampFloor(oldV + q);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 3; c++) mA[i][c] = 255;
            mDark[i]  = 0;
            mValid[i] = 0;
            mFirst[i] = 0;
        end
        pend  = 0;
        prevV = 1'b0;
        qDark.delete();
        qRgb.delete();
    endtask

    task automatic frameBoundary();
        int best;
        int cand [3];
        if (qDark.size() > 0 && pend == 0) begin
            best = 0;
            for (int j = 1; j < qDark.size(); j++)
                if (qDark[j] > qDark[best]) best = j;
            cand[0] = int'(qRgb[best][23:16]);
            cand[1] = int'(qRgb[best][15:8]);
            cand[2] = int'(qRgb[best][7:0]);
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 3; c++)
                    pendA[i][c] = smoothCh(mA[i][c], cand[c], (i == 0) ? 2 : 0, mFirst[i]);
                mFirst[i] = 1;
            end
            pendDark = qDark[best];
            pend = 3;
        end
        qDark.delete();
        qRgb.delete();
    endtask

    // One pixel-clock cycle: drive at the falling edge, advance the model,
    // then compare every output of both instances just after the rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic c,
                                 input logic [7:0] d, input logic [23:0] rgb);
        int expUpd;
        @(negedge clk);
        rst = r; vsync = v; clken = c; href = c; dark = d; img = rgb;
        if (r) begin
            modelReset();
        end else begin
            if (v && !prevV) frameBoundary();
            if (c) begin
                qDark.push_back(int'(d));
                qRgb.push_back(rgb);
            end
            prevV = v;
        end
        @(posedge clk);
        #1;
        expUpd = 0;
        if (!r && pend > 0) begin
            pend--;
            if (pend == 0) begin
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < 3; k++) mA[i][k] = pendA[i][k];
                    mDark[i]  = pendDark;
                    mValid[i] = 1;
                end
                expUpd = 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("d%0d.r", i), 32'(outR[i]), mA[i][0]);
            checkOutput($sformatf("d%0d.g", i), 32'(outG[i]), mA[i][1]);
            checkOutput($sformatf("d%0d.b", i), 32'(outB[i]), mA[i][2]);
            checkOutput($sformatf("d%0d.darkmax", i), 32'(outD[i]), mDark[i]);
            checkOutput($sformatf("d%0d.valid", i), 32'(outV[i]), mValid[i]);
            checkOutput($sformatf("d%0d.update", i), 32'(outU[i]), expUpd);
        end
    endtask

    // Frame boundary: vsync high for hiLen cycles, six cycles in total, and
    // the cycle index (0 = vsync-high cycle) where dut0 pulses.
    task automatic vsyncBoundary(input int hiLen, output int pulseIdx);
        pulseIdx = -1;
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1'b0, (s < hiLen), 1'b0, 8'd0, 24'd0);
            if (outU[0] === 1'b1 && pulseIdx < 0) pulseIdx = s;
        end
    endtask

    task automatic sendPixels();
        for (int p = 0; p < 16; p++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(pxDark[p]), pxRgb[p]);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; clken = 1'b0; href = 1'b0; dark = '0; img = '0;
        modelReset();

        // Reset held while pixels stream in
        for (int n = 0; n < 10; n++)
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 24'($urandom));
        checkOutput("rst.r", 32'(outR[0]), 255);
        checkOutput("rst.valid", 32'(outV[0]), 0);

        // Release mid-frame without pixels: the next rise must not commit
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        vsyncBoundary(2, pulseAt);
        checkOutput("empty_after_rst.pulse", 32'(pulseAt), -1);

        // First 4x4 frame: max 200 at (2,1), a later tie with a different colour
        for (int p = 0; p < 16; p++) begin
            pxDark[p] = $urandom_range(0, 199);
            pxRgb[p]  = 24'($urandom);
        end
        pxDark[6] = 200; pxRgb[6] = {8'd230, 8'd220, 8'd210};
        pxDark[12] = 200; pxRgb[12] = {8'd10, 8'd10, 8'd10};
        sendPixels();
        vsyncBoundary(2, pulseAt);
        checkOutput("first.pulse_cycle", 32'(pulseAt), 2);
        checkOutput("first.r", 32'(outR[0]), 230);
        checkOutput("first.g", 32'(outG[0]), 220);
        checkOutput("first.b", 32'(outB[0]), 210);
        checkOutput("first.dark", 32'(outD[0]), 200);

        // Smoothing frame: candidate (250,100,210)
        for (int p = 0; p < 16; p++) begin
            pxDark[p] = $urandom_range(0, 219);
            pxRgb[p]  = 24'($urandom);
        end
        pxDark[9] = 220; pxRgb[9] = {8'd250, 8'd100, 8'd210};
        sendPixels();
        vsyncBoundary(1, pulseAt);
        checkOutput("smooth.r", 32'(outR[0]), 235);
        checkOutput("smooth.g", 32'(outG[0]), 190);
        checkOutput("smooth.b", 32'(outB[0]), 210);
        checkOutput("noshift.g", 32'(outG[1]), 100);

        // Floor frame: candidate (80,120,60)
        for (int p = 0; p < 16; p++) begin
            pxDark[p] = $urandom_range(0, 179);
            pxRgb[p]  = 24'($urandom);
        end
        pxDark[3] = 180; pxRgb[3] = {8'd80, 8'd120, 8'd60};
        sendPixels();
        vsyncBoundary(2, pulseAt);
        checkOutput("floor.r", 32'(outR[1]), 100);
        checkOutput("floor.g", 32'(outG[1]), 120);
        checkOutput("floor.b", 32'(outB[1]), 100);
        checkOutput("floor_smooth.r", 32'(outR[0]), 196);
        checkOutput("floor_smooth.g", 32'(outG[0]), 172);
        checkOutput("floor_smooth.b", 32'(outB[0]), 172);

        // Empty frame: second rise with no pixels in between
        vsyncBoundary(2, pulseAt);
        checkOutput("empty.pulse", 32'(pulseAt), -1);
        checkOutput("empty.g", 32'(outG[1]), 120);

        // Boundary pixel: dark 255 arriving with the rise belongs to the next frame
        for (int p = 0; p < 16; p++) begin
            pxDark[p] = 50;
            pxRgb[p]  = 24'($urandom);
        end
        pxDark[5] = 100; pxRgb[5] = {8'd200, 8'd201, 8'd202};
        sendPixels();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd255, {8'd150, 8'd160, 8'd170});
        for (int n = 0; n < 5; n++) applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
        checkOutput("bpix_prev.dark", 32'(outD[1]), 100);
        checkOutput("bpix_prev.r", 32'(outR[1]), 200);
        for (int p = 0; p < 16; p++)
            applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom_range(0, 254)), 24'($urandom));
        vsyncBoundary(2, pulseAt);
        checkOutput("bpix.dark", 32'(outD[1]), 255);
        checkOutput("bpix.r", 32'(outR[1]), 150);
        checkOutput("bpix.g", 32'(outG[1]), 160);
        checkOutput("bpix.b", 32'(outB[1]), 170);

        // Randomized frames, including resets mid-frame and mid-update
        for (int f = 0; f < 30; f++) begin
            int np;
            np = $urandom_range(0, 30);
            for (int p = 0; p < np; p++) begin
                if (f == 12 && p == 5) begin
                    applyStimulus(1'b1, 1'b0, 1'b1, 8'($urandom), 24'($urandom));
                    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 24'd0);
                end
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0),
                              8'($urandom_range(0, 15) * 17), 24'($urandom));
            end
            if (f == 20) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 24'd0);
                applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 24'd0);
                applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 24'd0);
            end else begin
                applyStimulus(1'b0, 1'b1, 1'($urandom_range(0, 1)),
                              8'($urandom_range(0, 15) * 17), 24'($urandom));
                for (int n = 0; n < 5; n++)
                    applyStimulus(1'b0, 1'(n < int'($urandom_range(0, 2))), 1'($urandom_range(0, 1)),
                                  8'($urandom_range(0, 15) * 17), 24'($urandom));
            end
        end
        vsyncBoundary(2, pulseAt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
